// File: rtl/dsp_mult_bank.sv
// Pipelined multiplier bank: LANES independent WIDTH_IN x WIDTH_IN multipliers, LATENCY ce-edges deep.
// Define DSP_BANK_ACC_EN to make each lane multiply-accumulate into dsp_out (dsp_acc_clr restarts it).
module dsp_mult_bank #(
    parameter int LANES     = 5,
    parameter int WIDTH_IN  = 18,
    parameter int WIDTH_OUT = 37,
    parameter int LATENCY   = 2,
    parameter int SIGNED    = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dsp_ce,
    input  logic [LANES-1:0][WIDTH_IN-1:0]      dsp_a0,
    input  logic [LANES-1:0][WIDTH_IN-1:0]      dsp_b0,
    input  logic                                dsp_acc_clr,
    output logic [LANES-1:0][WIDTH_OUT-1:0]     dsp_out,
    output logic                                dsp_valid
);

    localparam int DEPTH = (LATENCY > 2) ? LATENCY - 2 : 1;

    // Product of two operands, widened to 2*WIDTH_IN then zero/sign-extended to WIDTH_OUT.
    function automatic logic [WIDTH_OUT-1:0] mul(input logic [WIDTH_IN-1:0] a,
                                                 input logic [WIDTH_IN-1:0] b);
        logic [2*WIDTH_IN-1:0] ax, bx, p;
        logic ext;
        if (SIGNED != 0) begin
            ax = {{WIDTH_IN{a[WIDTH_IN-1]}}, a};
            bx = {{WIDTH_IN{b[WIDTH_IN-1]}}, b};
        end else begin
            ax = {{WIDTH_IN{1'b0}}, a};
            bx = {{WIDTH_IN{1'b0}}, b};
        end
        p   = ax * bx;
        ext = (SIGNED != 0) ? p[2*WIDTH_IN-1] : 1'b0;
        return {{(WIDTH_OUT-2*WIDTH_IN){ext}}, p};
    endfunction

    logic [LANES-1:0][WIDTH_OUT-1:0] head_prod, last_prod;
    logic                            head_clr, last_clr;
    logic [2:0]                      fill_q;

    generate
        if (LATENCY == 1) begin : g_direct
            // Capture and product register collapse into dsp_out itself.
            always_comb begin
                for (int l = 0; l < LANES; l++) head_prod[l] = mul(dsp_a0[l], dsp_b0[l]);
                head_clr = dsp_acc_clr;
            end
        end else begin : g_stage0
            logic [LANES-1:0][WIDTH_IN-1:0] a_q, b_q;
            logic                           clr_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    clr_q <= 1'b0;
                end else if (dsp_ce) begin
                    a_q   <= dsp_a0;
                    b_q   <= dsp_b0;
                    clr_q <= dsp_acc_clr;
                end
            end
            always_comb begin
                for (int l = 0; l < LANES; l++) head_prod[l] = mul(a_q[l], b_q[l]);
                head_clr = clr_q;
            end
        end

        if (LATENCY > 2) begin : g_mid
            logic [DEPTH-1:0][LANES-1:0][WIDTH_OUT-1:0] mid_q;
            logic [DEPTH-1:0]                           mid_clr_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mid_q     <= '0;
                    mid_clr_q <= '0;
                end else if (dsp_ce) begin
                    mid_q[0]     <= head_prod;
                    mid_clr_q[0] <= head_clr;
                    for (int s = 1; s < DEPTH; s++) begin
                        mid_q[s]     <= mid_q[s-1];
                        mid_clr_q[s] <= mid_clr_q[s-1];
                    end
                end
            end
            assign last_prod = mid_q[DEPTH-1];
            assign last_clr  = mid_clr_q[DEPTH-1];
        end else begin : g_nomid
            assign last_prod = head_prod;
            assign last_clr  = head_clr;
        end
    endgenerate

`ifdef DSP_BANK_ACC_EN
    // Accumulate modulo 2^WIDTH_OUT; a clr tag aligned with its product reloads the lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_out <= '0;
        end else if (dsp_ce) begin
            for (int l = 0; l < LANES; l++) begin
                if (last_clr) dsp_out[l] <= last_prod[l];
                else          dsp_out[l] <= dsp_out[l] + last_prod[l];
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = last_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_out <= '0;
        end else if (dsp_ce) begin
            dsp_out <= last_prod;
        end
    end
`endif

    // Fill counter saturates at LATENCY; valid from the edge real data first reaches dsp_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
        end else if (dsp_ce && fill_q != 3'(LATENCY)) begin
            fill_q <= fill_q + 3'd1;
        end
    end

    assign dsp_valid = (fill_q == 3'(LATENCY));

endmodule

// File: tb/tb_dsp_mult_bank.sv
// Directed bench for dsp_mult_bank: unsigned/signed LATENCY=2 instances plus a LATENCY=3 instance.
module tb_dsp_mult_bank;

    localparam int LANES = 5;
    localparam int WI    = 18;
    localparam int WO    = 37;

    logic clk = 1'b0;
    logic rst, ce, clr;
    logic [LANES-1:0][WI-1:0] a, b;
    logic [LANES-1:0][WO-1:0] out_u, out_s, out_3;
    logic valid_u, valid_s, valid_3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_mult_bank #(.LANES(LANES), .WIDTH_IN(WI), .WIDTH_OUT(WO), .LATENCY(2), .SIGNED(0)) dut (
        .clk(clk), .rst(rst), .dsp_ce(ce), .dsp_a0(a), .dsp_b0(b),
        .dsp_acc_clr(clr), .dsp_out(out_u), .dsp_valid(valid_u)
    );

    dsp_mult_bank #(.LANES(LANES), .WIDTH_IN(WI), .WIDTH_OUT(WO), .LATENCY(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .dsp_ce(ce), .dsp_a0(a), .dsp_b0(b),
        .dsp_acc_clr(clr), .dsp_out(out_s), .dsp_valid(valid_s)
    );

    dsp_mult_bank #(.LANES(LANES), .WIDTH_IN(WI), .WIDTH_OUT(WO), .LATENCY(3), .SIGNED(0)) dut_3 (
        .clk(clk), .rst(rst), .dsp_ce(ce), .dsp_a0(a), .dsp_b0(b),
        .dsp_acc_clr(clr), .dsp_out(out_3), .dsp_valid(valid_3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        clr = 1'b0;
        a   = '0;
        b   = '0;
        step();
        step();
        check("rst_out_u0", 64'(out_u[0]), 64'd0);
        check("rst_out_s0", 64'(out_s[0]), 64'd0);
        check("rst_valid_u", 64'(valid_u), 64'd0);
        check("rst_valid_s", 64'(valid_s), 64'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef DSP_BANK_ACC_EN
        ce   = 1'b1;
        clr  = 1'b1;
        a[0] = 18'd2;
        b[0] = 18'd3;
        step();
        clr = 1'b0;
        check("acc_valid_pre", 64'(valid_u), 64'd0);
        step();
        check("acc_6", 64'(out_u[0]), 64'd6);
        check("acc_valid", 64'(valid_u), 64'd1);
        step();
        check("acc_12", 64'(out_u[0]), 64'd12);
        step();
        check("acc_18", 64'(out_u[0]), 64'd18);
        clr  = 1'b1;
        a[0] = 18'd1;
        b[0] = 18'd1;
        step();
        check("acc_24", 64'(out_u[0]), 64'd24);
        clr  = 1'b0;
        a[0] = 18'd0;
        b[0] = 18'd0;
        step();
        check("acc_reload_1", 64'(out_u[0]), 64'd1);
`else
        // Basic: 255*255 reaches dsp_out on the second ce edge.
        ce   = 1'b1;
        a[0] = 18'd255;
        b[0] = 18'd255;
        step();
        check("basic_out_e1", 64'(out_u[0]), 64'd0);
        check("basic_valid_e1", 64'(valid_u), 64'd0);
        step();
        check("basic_out_e2", 64'(out_u[0]), 64'd65025);
        check("basic_valid_e2", 64'(valid_u), 64'd1);
        check("l3_valid_pre", 64'(valid_3), 64'd0);

        // Streaming: lane k gets a=k+1+i, b=10 on edge i.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < LANES; k++) begin
                a[k] = 18'(k + 1 + i);
                b[k] = 18'd10;
            end
            step();
            for (int k = 0; k < LANES; k++) begin
                if (i >= 1)
                    check($sformatf("stream_l2_i%0d_k%0d", i, k), 64'(out_u[k]), 64'((k + i) * 10));
                if (i >= 2)
                    check($sformatf("stream_l3_i%0d_k%0d", i, k), 64'(out_3[k]), 64'((k + i - 1) * 10));
            end
        end
        check("l3_valid_post", 64'(valid_3), 64'd1);

        // CE stall: 3*7 captured, then ce low for 5 edges with changed operands.
        a[0] = 18'd3;
        b[0] = 18'd7;
        step();
        check("stall_before", 64'(out_u[0]), 64'd160);
        ce   = 1'b0;
        a[0] = 18'd9;
        b[0] = 18'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_hold_%0d", i), 64'(out_u[0]), 64'd160);
            check($sformatf("stall_valid_%0d", i), 64'(valid_u), 64'd1);
        end
        ce = 1'b1;
        step();
        check("stall_resume_21", 64'(out_u[0]), 64'd21);
        step();
        check("stall_next_81", 64'(out_u[0]), 64'd81);

        // Signed extremes versus the unsigned interpretation of the same bits.
        a[0] = 18'h20000;
        b[0] = 18'h20000;
        a[1] = 18'h3FFFF;
        b[1] = 18'h1FFFF;
        step();
        step();
        check("signed_min_sq", 64'(out_s[0]), 64'd17179869184);
        check("signed_m1_x_max", 64'(out_s[1]), 64'h1F_FFFE_0001);
        check("unsigned_lane0", 64'(out_u[0]), 64'd17179869184);
        check("unsigned_lane1", 64'(out_u[1]), 64'd34359345153);

        // Mid-operation reset between capture and output edges.
        a[0] = 18'd100;
        b[0] = 18'd100;
        step();
        #3;
        rst = 1'b1;
        #1;
        check("mrst_out_u0", 64'(out_u[0]), 64'd0);
        check("mrst_out_s1", 64'(out_s[1]), 64'd0);
        check("mrst_valid", 64'(valid_u), 64'd0);
        step();
        check("mrst_hold_out", 64'(out_u[0]), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        a[0] = 18'd4;
        b[0] = 18'd5;
        step();
        check("mrst_no_stale", 64'(out_u[0]), 64'd0);
        check("mrst_valid_e1", 64'(valid_u), 64'd0);
        step();
        check("mrst_new_20", 64'(out_u[0]), 64'd20);
        check("mrst_valid_e2", 64'(valid_u), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
